nes_controller_reader: RTL

Polls one NES controller over its 3-wire serial interface: generates latch and pulse, shifts in the 8 button bits and presents them as a registered, active-high button vector with a one-cycle valid strobe. Two instances sit directly upstream of the datapath paddle logic, one for the left controller and one for the right; their pins map to bidir[2:0] and bidir[5:3]. Runs on the pixel clock domain (25.175 MHz nominal).

---
 rtl/nes_controller_reader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/nes_controller_reader.sv
// nes_controller_reader: polls one NES pad over its latch/pulse/data wires and
// publishes the eight buttons as a registered active-high byte with a one-cycle strobe.
module nes_controller_reader #(
  parameter int LATCH_CYCLES      = 300,
  parameter int HALF_PULSE_CYCLES = 150,
  parameter int POLL_CYCLES       = 419583
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       buttons_valid
);

  localparam int POLL_W    = $clog2(POLL_CYCLES);
  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PULSE_CYCLES) ? LATCH_CYCLES : HALF_PULSE_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX);

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_PULSE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [POLL_W-1:0]  POLL_ONE   = POLL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_GAP      = 3'd2,
    S_PULSE_HI = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic [POLL_W-1:0]  r_poll;
  logic               w_tick;
  state_t             r_state;
  state_t             w_state_next;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_next;
  logic               w_phase_end;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_next;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_next;
  logic               w_sample;
  logic               r_latch;
  logic               r_pulse;
  logic [7:0]         r_buttons;
  logic [7:0]         w_buttons_next;
  logic               r_valid;

  assign w_tick   = (r_poll == POLL_LAST);
  assign w_sample = ~r_sync2;

  // Two-flop synchronizer for the asynchronous pad data; idles high like an unplugged pad.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= nes_data;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running poll period counter, independent of the transaction state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll <= '0;
    end else if (w_tick) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + POLL_ONE;
    end
  end

  // Detects the final cycle of the timed states.
  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      S_LATCH:           w_phase_end = (r_phase == LATCH_LAST);
      S_GAP, S_PULSE_HI: w_phase_end = (r_phase == HALF_LAST);
      default:           w_phase_end = 1'b0;
    endcase
  end

  // Next-state, bit capture and publish decisions.
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_buttons_next = r_buttons;
    case (r_state)
      S_IDLE: begin
        // Ticks outside IDLE are simply ignored: no pending poll is remembered.
        if (w_tick) begin
          w_state_next = S_LATCH;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LATCH: begin
        if (w_phase_end) begin
          w_state_next = S_GAP;
        end else begin
          w_state_next = S_LATCH;
        end
      end
      S_GAP: begin
        if (w_phase_end) begin
          w_shift_next[r_idx] = w_sample;
          if (r_idx == 3'd7) begin
            // Publish on DONE entry so the byte and its strobe appear in the same cycle.
            w_state_next   = S_DONE;
            w_buttons_next = {w_sample, r_shift[6:0]};
          end else begin
            w_state_next = S_PULSE_HI;
            w_idx_next   = r_idx + 3'd1;
          end
        end else begin
          w_state_next = S_GAP;
        end
      end
      S_PULSE_HI: begin
        if (w_phase_end) begin
          w_state_next = S_GAP;
        end else begin
          w_state_next = S_PULSE_HI;
        end
      end
      S_DONE: begin
        w_idx_next   = 3'd0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_idx_next   = 3'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Phase counter restarts on every state entry and stays parked while idle.
  always_comb begin
    if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
      w_phase_next = '0;
    end else begin
      w_phase_next = r_phase + PHASE_ONE;
    end
  end

  // Transaction state, phase, bit index and shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
    end
  end

  // Registered pad-facing and datapath-facing outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_buttons <= 8'h00;
    end else begin
      r_latch   <= (w_state_next == S_LATCH);
      r_pulse   <= (w_state_next == S_PULSE_HI);
      r_valid   <= (w_state_next == S_DONE);
      r_buttons <= w_buttons_next;
    end
  end

  assign nes_latch     = r_latch;
  assign nes_pulse     = r_pulse;
  assign buttons       = r_buttons;
  assign buttons_valid = r_valid;

endmodule
